// File: rtl/clk_div_cfg_initiator.sv
// clk_div_cfg_initiator
// Initiator side of the clock-divider configuration handshake. Accepts a divide
// value on a local valid/ready port, then runs a four-phase level handshake
// (valid up, ack up, valid down, ack down) toward a divider in another clock
// domain. The ack input is resynchronised here, and each handshake phase is
// guarded by a timeout so a dead divider cannot hang the controller.
//
// Ports:
//   clk_i            configuration-domain clock
//   rst_i            synchronous reset, active-high
//   req_valid_i      new divide value offered
//   req_ready_o      request accepted when req_valid_i && req_ready_o
//   req_div_i        divide value to program
//   clk_div_data_o   divide value toward the divider (registered)
//   clk_div_valid_o  handshake request level toward the divider (registered)
//   clk_div_ack_i    asynchronous acknowledge level from the divider
//   busy_o           handshake in progress
//   done_o           one-cycle pulse, handshake completed normally
//   timeout_o        one-cycle pulse, a handshake phase timed out
//   cur_div_o        last value acknowledged by the divider
module clk_div_cfg_initiator #(
  parameter int unsigned              DIV_WIDTH      = 8,
  parameter logic [DIV_WIDTH-1:0]     DIV_INIT       = '0,
  parameter int unsigned              SYNC_STAGES    = 2,
  parameter int unsigned              TIMEOUT_CYCLES = 1024
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [DIV_WIDTH-1:0] req_div_i,
  output logic [DIV_WIDTH-1:0] clk_div_data_o,
  output logic                 clk_div_valid_o,
  input  logic                 clk_div_ack_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 timeout_o,
  output logic [DIV_WIDTH-1:0] cur_div_o
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
  localparam bit TO_EN = (TIMEOUT_CYCLES != 0);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_REL  = 2'd2
  } state_e;

  state_e                 state_q,    state_d;
  logic [SYNC_STAGES-1:0] ack_sync_q, ack_sync_d;
  logic [DIV_WIDTH-1:0]   data_q,     data_d;
  logic [DIV_WIDTH-1:0]   cur_q,      cur_d;
  logic                   valid_q,    valid_d;
  logic                   done_q,     done_d;
  logic                   timeout_q,  timeout_d;
  logic                   abort_q,    abort_d;
  logic [CNT_W-1:0]       cnt_q,      cnt_d;

  logic ack_s;
  logic req_ready;
  logic phase_expired;

  assign ack_s         = ack_sync_q[SYNC_STAGES-1];
  assign req_ready     = (state_q == ST_IDLE) && !ack_s;
  assign phase_expired = TO_EN && (cnt_q == CNT_LAST);

  // Next-state and output logic
  always_comb begin
    ack_sync_d = {ack_sync_q[SYNC_STAGES-2:0], clk_div_ack_i};
    state_d    = state_q;
    data_d     = data_q;
    cur_d      = cur_q;
    valid_d    = valid_q;
    done_d     = 1'b0;
    timeout_d  = 1'b0;
    abort_d    = abort_q;
    cnt_d      = cnt_q + CNT_W'(1);

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (req_valid_i && req_ready) begin
          data_d  = req_div_i;
          valid_d = 1'b1;
          abort_d = 1'b0;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        // Ack arriving on the last allowed cycle still counts as success.
        if (ack_s) begin
          cur_d   = data_q;
          valid_d = 1'b0;
          cnt_d   = '0;
          state_d = ST_REL;
        end else if (phase_expired) begin
          timeout_d = 1'b1;
          valid_d   = 1'b0;
          abort_d   = 1'b1;
          cnt_d     = '0;
          state_d   = ST_REL;
        end
      end
      ST_REL: begin
        // An aborted handshake still waits for ack low but reports no done.
        if (!ack_s) begin
          done_d  = !abort_q;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else if (phase_expired) begin
          timeout_d = 1'b1;
          cnt_d     = '0;
          state_d   = ST_IDLE;
        end
      end
      default: begin
        valid_d = 1'b0;
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; the ack synchroniser resets high so no
  // request is taken until a low ack has crossed the chain.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      ack_sync_q <= '1;
      data_q     <= DIV_INIT;
      cur_q      <= DIV_INIT;
      valid_q    <= 1'b0;
      done_q     <= 1'b0;
      timeout_q  <= 1'b0;
      abort_q    <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      ack_sync_q <= ack_sync_d;
      data_q     <= data_d;
      cur_q      <= cur_d;
      valid_q    <= valid_d;
      done_q     <= done_d;
      timeout_q  <= timeout_d;
      abort_q    <= abort_d;
      cnt_q      <= cnt_d;
    end
  end

  assign req_ready_o     = req_ready;
  assign clk_div_data_o  = data_q;
  assign clk_div_valid_o = valid_q;
  assign busy_o          = (state_q != ST_IDLE);
  assign done_o          = done_q;
  assign timeout_o       = timeout_q;
  assign cur_div_o       = cur_q;

endmodule

// File: tb/tb_clk_div_cfg_initiator.sv
// Directed bench for clk_div_cfg_initiator: reset state, basic and back-to-back
// handshakes, REQ timeout, ack/timeout tie, reset mid-handshake, and a small
// behavioural divider on an asynchronous clock for integration.
module tb_clk_div_cfg_initiator;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic [7:0] req_div;
  logic [7:0] data_o;
  logic       valid_o;
  logic       ack;
  logic       busy;
  logic       done;
  logic       timeout;
  logic [7:0] cur;

  int n_cmp = 0;
  int n_bad = 0;

  // Ack source: 0 = man_ack, 1 = valid_o delayed 3 cycles, 2 = divider model
  int         ack_mode = 0;
  logic       man_ack  = 1'b0;
  logic [2:0] ack_pipe = 3'b000;

  // Behavioural divider on its own clock (period 27 vs 100)
  logic       dclk = 1'b0;
  logic [1:0] vs   = 2'b00;
  logic       dack = 1'b0;
  int         ddiv = 1;
  int         dcnt = 0;

  clk_div_cfg_initiator #(
    .DIV_WIDTH      (8),
    .DIV_INIT       (8'h00),
    .SYNC_STAGES    (2),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .req_valid_i     (req_valid),
    .req_ready_o     (req_ready),
    .req_div_i       (req_div),
    .clk_div_data_o  (data_o),
    .clk_div_valid_o (valid_o),
    .clk_div_ack_i   (ack),
    .busy_o          (busy),
    .done_o          (done),
    .timeout_o       (timeout),
    .cur_div_o       (cur)
  );

  always #50 clk = ~clk;
  always begin
    #14 dclk = 1'b1;
    #13 dclk = 1'b0;
  end

  always @(posedge clk) ack_pipe <= {ack_pipe[1:0], valid_o};

  always @(posedge dclk) begin
    vs <= {vs[0], valid_o};
    if (vs[1] && !dack) begin
      ddiv <= int'(data_o);
      dack <= 1'b1;
    end else if (!vs[1]) begin
      dack <= 1'b0;
    end
    if (dcnt >= ddiv - 1) dcnt <= 0;
    else                  dcnt <= dcnt + 1;
  end

  assign ack = (ack_mode == 0) ? man_ack : (ack_mode == 1) ? ack_pipe[2] : dack;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Program one value through the divider model; ok=1 on done, 0 otherwise.
  task automatic program_div(input logic [7:0] v, output int ok);
    for (int k = 0; k < 50 && !req_ready; k++) tick();
    req_div   = v;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    ok = 0;
    for (int k = 0; k < 100; k++) begin
      tick();
      if (done) begin
        ok = 1;
        break;
      end
      if (timeout) break;
    end
  endtask

  // Divider output period in divider-clock cycles (bounded).
  task automatic measure(output int per);
    per = 0;
    for (int k = 0; k < 600; k++) begin
      @(negedge dclk);
      if (dcnt == 0) break;
    end
    for (int k = 0; k < 600; k++) begin
      @(negedge dclk);
      per++;
      if (dcnt == 0) break;
    end
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int done_idx, n_done, n_vhi, bad_data, n_to;
    int n_acc, acc_idx2, viol, to_idx, v16, b17, ok, nok, curbad, per;
    logic acc;
    logic [7:0] v;

    rst = 1'b1; req_valid = 1'b0; req_div = 8'h00;
    tick(); tick();
    // Reset state
    check("rst_valid",   32'(valid_o),   32'd0);
    check("rst_busy",    32'(busy),      32'd0);
    check("rst_done",    32'(done),      32'd0);
    check("rst_timeout", 32'(timeout),   32'd0);
    check("rst_data",    32'(data_o),    32'h00);
    check("rst_cur",     32'(cur),       32'h00);
    check("rst_ready",   32'(req_ready), 32'd0);
    rst = 1'b0;
    tick();
    check("rel_ready1", 32'(req_ready), 32'd0);
    tick();
    check("rel_ready2", 32'(req_ready), 32'd1);

    // 1: basic handshake, ack follows valid with 3-cycle delay
    ack_mode = 1;
    req_div = 8'h05; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    check("t1_valid_next", 32'(valid_o),   32'd1);
    check("t1_data",       32'(data_o),    32'h05);
    check("t1_busy",       32'(busy),      32'd1);
    check("t1_ready_busy", 32'(req_ready), 32'd0);
    done_idx = -1; n_done = 0; n_vhi = 0; bad_data = 0; n_to = 0;
    for (int i = 1; i <= 30; i++) begin
      tick();
      if (done) begin
        n_done++;
        if (done_idx < 0) done_idx = i;
      end
      if (valid_o) n_vhi++;
      if (data_o != 8'h05) bad_data++;
      if (timeout) n_to++;
    end
    check("t1_done_idx",  32'(done_idx), 32'd12);
    check("t1_done_cnt",  32'(n_done),   32'd1);
    check("t1_valid_len", 32'(n_vhi),    32'd5);
    check("t1_data_hold", 32'(bad_data), 32'd0);
    check("t1_timeouts",  32'(n_to),     32'd0);
    check("t1_cur",       32'(cur),      32'h05);

    // 2: back-to-back with valid held
    req_div = 8'h05; req_valid = 1'b1;
    n_acc = 0; acc_idx2 = -1; done_idx = -1; n_done = 0; viol = 0;
    for (int i = 0; i <= 60; i++) begin
      acc = req_valid && req_ready;
      tick();
      if (acc) begin
        n_acc++;
        if (n_acc == 1) req_div = 8'h0A;
        else begin
          req_valid = 1'b0;
          acc_idx2  = i;
        end
      end
      if (busy && req_ready) viol++;
      if (done) begin
        n_done++;
        if (done_idx < 0) done_idx = i;
      end
    end
    check("t2_first_done", 32'(done_idx), 32'd12);
    check("t2_acc2_idx",   32'(acc_idx2), 32'd13);
    check("t2_accepts",    32'(n_acc),    32'd2);
    check("t2_ready_busy", 32'(viol),     32'd0);
    check("t2_done_cnt",   32'(n_done),   32'd2);
    check("t2_cur",        32'(cur),      32'h0A);

    // 3: REQ timeout with ack stuck low
    ack_mode = 0; man_ack = 1'b0;
    req_div = 8'h33; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    to_idx = -1; n_to = 0; n_done = 0; v16 = -1; b17 = -1;
    for (int i = 1; i <= 25; i++) begin
      tick();
      if (timeout) begin
        n_to++;
        if (to_idx < 0) to_idx = i;
      end
      if (done) n_done++;
      if (i == 16) v16 = int'(valid_o);
      if (i == 17) b17 = int'(busy);
    end
    check("t3_to_idx",   32'(to_idx), 32'd16);
    check("t3_to_cnt",   32'(n_to),   32'd1);
    check("t3_valid_dn", 32'(v16),    32'd0);
    check("t3_rel_exit", 32'(b17),    32'd0);
    check("t3_no_done",  32'(n_done), 32'd0);
    check("t3_cur",      32'(cur),    32'h0A);
    check("t3_data",     32'(data_o), 32'h33);

    // 4: ack_s rises on the cycle the counter reaches 15
    req_div = 8'h44; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    done_idx = -1; n_to = 0; n_done = 0;
    for (int i = 1; i <= 30; i++) begin
      tick();
      if (timeout) n_to++;
      if (done) begin
        n_done++;
        if (done_idx < 0) done_idx = i;
      end
      if (i == 13) man_ack = 1'b1;
      if (i == 15) begin
        check("t4_valid15", 32'(valid_o), 32'd1);
        check("t4_cur15",   32'(cur),     32'h0A);
      end
      if (i == 16) begin
        check("t4_timeout", 32'(timeout), 32'd0);
        check("t4_busy",    32'(busy),    32'd1);
        check("t4_valid",   32'(valid_o), 32'd0);
        check("t4_cur",     32'(cur),     32'h44);
        man_ack = 1'b0;
      end
    end
    check("t4_done_idx", 32'(done_idx), 32'd19);
    check("t4_done_cnt", 32'(n_done),   32'd1);
    check("t4_to_cnt",   32'(n_to),     32'd0);

    // 5: reset while in REQ with ack high
    req_div = 8'h55; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    man_ack = 1'b1;
    tick();
    rst = 1'b1;
    tick();
    check("t5_valid",   32'(valid_o),   32'd0);
    check("t5_data",    32'(data_o),    32'h00);
    check("t5_cur",     32'(cur),       32'h00);
    check("t5_busy",    32'(busy),      32'd0);
    check("t5_done",    32'(done),      32'd0);
    check("t5_timeout", 32'(timeout),   32'd0);
    check("t5_ready",   32'(req_ready), 32'd0);
    rst = 1'b0;
    tick(); tick(); tick();
    check("t5_ready_ackhi", 32'(req_ready), 32'd0);
    man_ack = 1'b0;
    tick();
    check("t5_ready_f1", 32'(req_ready), 32'd0);
    tick();
    check("t5_ready_f2", 32'(req_ready), 32'd1);

    // 6: integration with the asynchronous divider model
    ack_mode = 2;
    program_div(8'h0A, ok);
    check("t6_ok",  32'(ok),  32'd1);
    check("t6_cur", 32'(cur), 32'h0A);
    measure(per);
    check("t6_period", 32'(per), 32'd10);
    nok = 0; curbad = 0; v = 8'h0A;
    for (int i = 0; i < 100; i++) begin
      v = 8'($urandom_range(2, 255));
      program_div(v, ok);
      if (ok == 1) nok++;
      if (cur != v) curbad++;
    end
    check("t6_rand_ok",  32'(nok),    32'd100);
    check("t6_rand_cur", 32'(curbad), 32'd0);
    measure(per);
    check("t6_last_period", 32'(per), 32'(v));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
